// File: rtl/lap_logger_pkg.sv
// Shared definitions for the lap logger slice.
// Contents: digit and time-word widths, the default lap store depth, the lap
// store state encoding, and a helper that packs four BCD digits into the
// {min_t,min_u,sec_t,sec_u} word used by the lap store and the read port.
package lap_logger_pkg;

  localparam int unsigned DIGIT_W       = 4;
  localparam int unsigned TIME_W        = 16;
  localparam int unsigned LAP_DEPTH_DEF = 8;

  typedef logic [DIGIT_W-1:0] bcd_t;
  typedef logic [TIME_W-1:0]  time_word_t;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } lap_state_t;

  function automatic time_word_t pack_time(input bcd_t min_t, input bcd_t min_u,
                                           input bcd_t sec_t, input bcd_t sec_u);
    return {min_t, min_u, sec_t, sec_u};
  endfunction

endpackage

// File: rtl/lap_logger_if.sv
// Lap store read port.
// Signals:
//   rd_en    read request, sampled each cycle (master -> slave)
//   rd_addr  lap slot to read                  (master -> slave)
//   rd_data  slot contents, one cycle later    (slave -> master)
//   rd_valid one-cycle qualifier for rd_data   (slave -> master)
interface lap_logger_if #(
  parameter int unsigned ADDR_W = 3
);
  import lap_logger_pkg::*;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  time_word_t        rd_data;
  logic              rd_valid;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data,
    input  rd_valid
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data,
    output rd_valid
  );

endinterface

// File: rtl/lap_logger_bcd_time_acc.sv
// bcd_time_acc: four-digit BCD MM:SS accumulator.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   tick            advance time by one second
//   clear           zero the time (wins over tick)
//   sec_u..min_t    registered BCD digits
//   rollover        one-cycle pulse when MAX_MIN:59 wraps to 00:00
module bcd_time_acc
  import lap_logger_pkg::*;
#(
  parameter int unsigned MAX_MIN = 99
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic clear,
  output bcd_t sec_u,
  output bcd_t sec_t,
  output bcd_t min_u,
  output bcd_t min_t,
  output logic rollover
);

  localparam bcd_t MAX_MT = DIGIT_W'(MAX_MIN / 10);
  localparam bcd_t MAX_MU = DIGIT_W'(MAX_MIN % 10);

  bcd_t sec_u_n, sec_t_n, min_u_n, min_t_n;
  logic at_max;

  assign at_max = (min_t == MAX_MT) && (min_u == MAX_MU) &&
                  (sec_t == 4'd5) && (sec_u == 4'd9);

  // Carry cascade; only consulted when tick is high and not at_max, so
  // min_t can never step past the tens digit of MAX_MIN.
  always_comb begin
    sec_u_n = sec_u;
    sec_t_n = sec_t;
    min_u_n = min_u;
    min_t_n = min_t;
    if (sec_u != 4'd9) begin
      sec_u_n = sec_u + 4'd1;
    end else begin
      sec_u_n = '0;
      if (sec_t != 4'd5) begin
        sec_t_n = sec_t + 4'd1;
      end else begin
        sec_t_n = '0;
        if (min_u != 4'd9) begin
          min_u_n = min_u + 4'd1;
        end else begin
          min_u_n = '0;
          min_t_n = min_t + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sec_u    <= '0;
      sec_t    <= '0;
      min_u    <= '0;
      min_t    <= '0;
      rollover <= 1'b0;
    end else begin
      rollover <= 1'b0;
      if (tick) begin
        if (at_max) begin
          sec_u    <= '0;
          sec_t    <= '0;
          min_u    <= '0;
          min_t    <= '0;
          rollover <= 1'b1;
        end else begin
          sec_u <= sec_u_n;
          sec_t <= sec_t_n;
          min_u <= min_u_n;
          min_t <= min_t_n;
        end
      end
    end
  end

endmodule

// File: rtl/lap_logger.sv
// lap_logger: MM:SS time accumulator driven by tick, with a lap store.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   tick            one-cycle pulse, advance time by one second
//   clear           zero time, empty lap store, clear overflow
//   lap             capture current displayed time into the next slot
//   bus (slave)     registered read port: rd_en/rd_addr -> rd_data/rd_valid
//   sec_u..min_t    BCD time digits
//   rollover        one-cycle pulse on MAX_MIN:59 -> 00:00
//   lap_count       number of valid entries, 0..LAP_DEPTH
//   full            lap_count == LAP_DEPTH
//   overflow        sticky: lap arrived while full
module lap_logger
  import lap_logger_pkg::*;
#(
  parameter int unsigned LAP_DEPTH = LAP_DEPTH_DEF,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned MAX_MIN   = 99
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              clear,
  input  logic              lap,
  lap_logger_if.slave       bus,
  output bcd_t              sec_u,
  output bcd_t              sec_t,
  output bcd_t              min_u,
  output bcd_t              min_t,
  output logic              rollover,
  output logic [ADDR_W:0]   lap_count,
  output logic              full,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(LAP_DEPTH);

  bcd_time_acc #(
    .MAX_MIN (MAX_MIN)
  ) u_time (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .clear    (clear),
    .sec_u    (sec_u),
    .sec_t    (sec_t),
    .min_u    (min_u),
    .min_t    (min_t),
    .rollover (rollover)
  );

  // Registered time as currently displayed; a simultaneous tick only
  // affects the next cycle, so the captured value is pre-increment.
  time_word_t time_word;
  assign time_word = pack_time(min_t, min_u, sec_t, sec_u);

  lap_state_t        state, state_n;
  logic [ADDR_W:0]   cnt_n;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_n, wr_addr;
  logic              overflow_n;
  logic              we;

  time_word_t mem [LAP_DEPTH];

  always_comb begin
    state_n    = state;
    cnt_n      = lap_count;
    wr_ptr_n   = wr_ptr;
    overflow_n = overflow;
    we         = 1'b0;
    wr_addr    = wr_ptr;
    if (clear) begin
      state_n    = ST_EMPTY;
      cnt_n      = '0;
      wr_ptr_n   = '0;
      overflow_n = 1'b0;
    end else if (lap) begin
      case (state)
        ST_EMPTY: begin
          we       = 1'b1;
          wr_addr  = '0;
          wr_ptr_n = ADDR_W'(1);
          cnt_n    = (ADDR_W + 1)'(1);
          state_n  = (DEPTH_C == (ADDR_W + 1)'(1)) ? ST_FULL : ST_PARTIAL;
        end
        ST_PARTIAL: begin
          we       = 1'b1;
          wr_ptr_n = wr_ptr + ADDR_W'(1);
          cnt_n    = lap_count + (ADDR_W + 1)'(1);
          state_n  = (cnt_n == DEPTH_C) ? ST_FULL : ST_PARTIAL;
        end
        ST_FULL: begin
          overflow_n = 1'b1;
        end
        default: begin
          state_n = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      lap_count <= '0;
      wr_ptr    <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      lap_count <= cnt_n;
      wr_ptr    <= wr_ptr_n;
      overflow  <= overflow_n;
    end
  end

  assign full = (state == ST_FULL);

  // Storage itself is not reset: validity comes from lap_count alone.
  always_ff @(posedge clk) begin
    if (!rst && we) begin
      mem[wr_addr] <= time_word;
    end
  end

  // Read sees pre-write state, so a read of the slot being written this
  // cycle returns the invalid (zero) result.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        bus.rd_data <= ({1'b0, bus.rd_addr} < lap_count) ? mem[bus.rd_addr] : '0;
      end
    end
  end

endmodule

// File: tb/tb_lap_logger.sv
module tb_lap_logger;
  import lap_logger_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
  localparam int          MAX_T = 99 * 60 + 59;

  logic        clk = 1'b0;
  logic        rst, tick, clear, lap;
  bcd_t        sec_u, sec_t, min_u, min_t;
  logic        rollover, full, overflow;
  logic [AW:0] lap_count;
  logic [15:0] disp;

  lap_logger_if #(.ADDR_W(AW)) bus ();

  lap_logger #(
    .LAP_DEPTH (DEPTH),
    .ADDR_W    (AW),
    .MAX_MIN   (99)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .clear     (clear),
    .lap       (lap),
    .bus       (bus),
    .sec_u     (sec_u),
    .sec_t     (sec_t),
    .min_u     (min_u),
    .min_t     (min_t),
    .rollover  (rollover),
    .lap_count (lap_count),
    .full      (full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  assign disp = {min_t, min_u, sec_t, sec_u};

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [15:0] exp_q[$];
  int          m_time = 0;
  logic [15:0] m_laps [DEPTH];
  int          m_cnt = 0;
  logic        m_ovf = 1'b0;
  logic [15:0] m_rd_last = 16'h0000;

  function automatic logic [15:0] to_word(input int t);
    int mm, ss;
    mm = t / 60;
    ss = t % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: advance the reference model from the driven inputs, clock,
  // release inputs, and compare every observable output.
  task automatic cyc();
    logic        was_rd, exp_roll;
    logic [15:0] rexp;
    was_rd   = bus.rd_en && !rst;
    exp_roll = !rst && !clear && tick && (m_time == MAX_T);
    if (rst || clear) begin
      m_time = 0;
      m_cnt  = 0;
      m_ovf  = 1'b0;
      if (rst) m_rd_last = 16'h0000;
    end else begin
      if (lap) begin
        if (m_cnt == DEPTH) m_ovf = 1'b1;
        else begin
          m_laps[m_cnt] = to_word(m_time);
          m_cnt++;
        end
      end
      if (tick) m_time = (m_time == MAX_T) ? 0 : m_time + 1;
    end
    @(posedge clk);
    #1;
    rst = 1'b0; tick = 1'b0; clear = 1'b0; lap = 1'b0;
    bus.rd_en = 1'b0;
    chk("time", disp, to_word(m_time));
    chk("rollover", rollover, exp_roll);
    chk("lap_count", lap_count, m_cnt);
    chk("full", full, m_cnt == DEPTH);
    chk("overflow", overflow, m_ovf);
    chk("rd_valid", bus.rd_valid, was_rd);
    if (was_rd) begin
      if (exp_q.size() == 0) begin
        chk("rd_queue_empty", 32'd0, 32'd1);
      end else begin
        rexp = exp_q.pop_front();
        m_rd_last = rexp;
      end
    end
    chk("rd_data", bus.rd_data, m_rd_last);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
    end
  endtask

  task automatic clr();
    clear = 1'b1;
    cyc();
  endtask

  task automatic rd(input int addr, input logic [15:0] exp);
    bus.rd_en   = 1'b1;
    bus.rd_addr = AW'(addr);
    exp_q.push_back(exp);
    cyc();
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; clear = 1'b0; lap = 1'b0;
    bus.rd_en = 1'b0; bus.rd_addr = '0;
    cyc();
    rst = 1'b1;
    cyc();
    chk("rst_time", disp, 16'h0000);
    chk("rst_count", lap_count, 0);
    chk("rst_flags", {rollover, full, overflow, bus.rd_valid}, 4'b0000);

    ticks(75);
    chk("t_0115", disp, 16'h0115);
    chk("t_0115_flags", {lap_count, full, overflow}, 6'b0);

    clr();
    ticks(MAX_T);
    chk("t_9959", disp, 16'h9959);
    tick = 1'b1;
    cyc();
    chk("roll_time", disp, 16'h0000);
    chk("roll_hi", rollover, 1'b1);
    cyc();
    chk("roll_lo", rollover, 1'b0);

    // Laps at 00:03 (with same-slot read), 00:10, 01:00.
    clr();
    ticks(3);
    lap = 1'b1;
    bus.rd_en = 1'b1; bus.rd_addr = '0;
    exp_q.push_back(16'h0000);
    cyc();
    ticks(7);
    lap = 1'b1;
    cyc();
    ticks(50);
    lap = 1'b1;
    cyc();
    rd(0, 16'h0003);
    rd(1, 16'h0010);
    rd(2, 16'h0100);
    cyc();
    chk("rd_hold", bus.rd_data, 16'h0100);
    rd(5, 16'h0000);

    // Tick and lap together at 00:09.
    clr();
    ticks(9);
    tick = 1'b1; lap = 1'b1;
    cyc();
    chk("tl_time", disp, 16'h0010);
    rd(0, 16'h0009);

    // Nine laps into an eight-deep store; lap i taken at 00:0i.
    clr();
    for (int i = 0; i < 9; i++) begin
      lap = 1'b1;
      cyc();
      if (i == 7) chk("full_at_8", {full, overflow}, 2'b10);
      if (i == 8) chk("ovf_at_9", {full, overflow}, 2'b11);
      tick = 1'b1;
      cyc();
    end
    rd(7, 16'h0007);
    chk("ovf_sticky", overflow, 1'b1);
    clr();
    chk("clr_state", {lap_count, full, overflow}, 6'b0);
    chk("clr_time", disp, 16'h0000);

    // Reset mid-run at 00:42 with 3 laps, alongside lap and tick.
    ticks(5);
    lap = 1'b1; cyc();
    ticks(10);
    lap = 1'b1; cyc();
    ticks(20);
    lap = 1'b1; cyc();
    ticks(7);
    chk("pre_rst_time", disp, 16'h0042);
    chk("pre_rst_count", lap_count, 3);
    rst = 1'b1; lap = 1'b1; tick = 1'b1;
    cyc();
    chk("mid_rst_time", disp, 16'h0000);
    chk("mid_rst_flags", {lap_count, full, overflow, rollover, bus.rd_valid}, 8'b0);
    rd(0, 16'h0000);
    rd(1, 16'h0000);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
